// File: rtl/bus_pkg.sv
// bus_pkg: phase codes and responder FSM encoding shared by both ends of the byte bus
package bus_pkg;
  typedef enum logic [1:0] {
    PH_ADDR_LO = 2'd0,
    PH_ADDR_HI = 2'd1,
    PH_WRITE   = 2'd2,
    PH_READ    = 2'd3
  } phase_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_ACK  = 2'd2
  } state_e;
endpackage

// File: rtl/bus_responder_sync_hi.sv
// sync_hi: N-stage synchronizer, resets to 0
// ports: clk, rst (sync, active high), d_i async input, q_o synchronized output
module sync_hi #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] q_q;
  always_ff @(posedge clk)
    if (rst) q_q <= '0;
    else     q_q <= {q_q[N-2:0], d_i};
  assign q_o = q_q[N-1];
endmodule

// File: rtl/bus_responder.sv
// bus_responder: four-phase byte-bus target bridging to a variable-latency memory port
// bus side: bus_handshake_req/bus_state/bus_data_in in, bus_handshake_ack/bus_data_out/bus_output_enable out
// memory side: mem_addr/mem_read/mem_write/mem_wdata out, mem_rdata/mem_done in; proto_err sticky flag
module bus_responder
  import bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_handshake_req,
  input  logic [1:0]  bus_state,
  input  logic [7:0]  bus_data_in,
  output logic        bus_handshake_ack,
  output logic [7:0]  bus_data_out,
  output logic        bus_output_enable,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_done,
  output logic        proto_err
);
  logic req_s;
  state_e state_q, state_d;
  logic ack_q, ack_d, oe_q, oe_d, rd_q, rd_d, wr_q, wr_d, err_q, err_d;
  logic is_rd_q, is_rd_d, abort_q, abort_d;
  logic [7:0] dout_q, dout_d, wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  sync_hi #(.N(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus_handshake_req),
    .q_o (req_s)
  );
  // bus_state/bus_data_in are sampled raw: they settled before req made it through the synchronizer
  always_comb begin
    state_d = state_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    is_rd_d = is_rd_q;
    abort_d = abort_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    case (state_q)
      ST_IDLE:
        if (req_s)
          case (phase_e'(bus_state))
            PH_ADDR_LO: begin addr_d[7:0] = bus_data_in; state_d = ST_ACK; end
            PH_ADDR_HI: begin addr_d[15:8] = bus_data_in; state_d = ST_ACK; end
            PH_WRITE:   begin wdata_d = bus_data_in; wr_d = 1'b1; is_rd_d = 1'b0; state_d = ST_MEM; end
            default:    begin rd_d = 1'b1; is_rd_d = 1'b1; state_d = ST_MEM; end
          endcase
      ST_MEM: begin
        // an abandoned transfer still completes so memory and address stay coherent
        if (!req_s) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
        end
        if (mem_done) begin
          dout_d  = is_rd_q ? mem_rdata : dout_q;
          oe_d    = is_rd_q;
          addr_d  = addr_q + 16'd1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:
        // abort forces a single ack cycle even if req has already come back
        if (!req_s || abort_q) begin
          oe_d    = 1'b0;
          abort_d = 1'b0;
          state_d = ST_IDLE;
        end
      default: state_d = ST_IDLE;
    endcase
    ack_d = state_d == ST_ACK;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= 8'h00;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      is_rd_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      is_rd_q <= is_rd_d;
      abort_q <= abort_d;
    end
  assign bus_handshake_ack = ack_q;
  assign bus_output_enable = oe_q;
  assign bus_data_out      = dout_q;
  assign mem_addr          = addr_q;
  assign mem_wdata         = wdata_q;
  assign mem_read          = rd_q;
  assign mem_write         = wr_q;
  assign proto_err         = err_q;
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: directed scenario bench for bus_responder
module tb_bus_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic [1:0] bstate = 2'd0;
  logic [7:0] din = 8'h00;
  logic ack, oe, mrd, mwr, mdone = 1'b0, perr;
  logic [7:0] dout, wdata, rdata = 8'h00;
  logic [15:0] addr;
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  bus_responder #(.SYNC_STAGES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus_handshake_req (req),
    .bus_state         (bstate),
    .bus_data_in       (din),
    .bus_handshake_ack (ack),
    .bus_data_out      (dout),
    .bus_output_enable (oe),
    .mem_addr          (addr),
    .mem_read          (mrd),
    .mem_write         (mwr),
    .mem_wdata         (wdata),
    .mem_rdata         (rdata),
    .mem_done          (mdone),
    .proto_err         (perr)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic bit cond(input int w);
    return w == 0 ? mwr : w == 1 ? mrd : w == 2 ? ack : !ack;
  endfunction
  // w: 0 write strobe, 1 read strobe, 2 ack high, 3 ack low
  task automatic wait_for(input int w, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cond(w)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic do_phase(input logic [1:0] ph, input logic [7:0] d, output bit ok);
    bit a, b;
    bstate = ph;
    din = d;
    req = 1'b1;
    wait_for(2, a);
    req = 1'b0;
    wait_for(3, b);
    ok = a && b;
  endtask
  task automatic finish_xfer(output bit ok);
    req = 1'b0;
    wait_for(3, ok);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({ack, oe, mrd, mwr, perr, dout, wdata, addr} !== 37'd0)
      $display("FAIL reset_values got ack=%b oe=%b rd=%b wr=%b err=%b dout=%h wdata=%h addr=%h want all 0", ack, oe, mrd, mwr, perr, dout, wdata, addr);
    else passed++;
    rst = 1'b0;
    tick();
  endtask
  task automatic test_write();
    bit ok, ok2;
    do_phase(2'd0, 8'h34, ok);
    do_phase(2'd1, 8'h12, ok2);
    checks++;
    if ({ok, ok2} !== 2'b11) $display("FAIL addr_phases_handshake got %b want 11", {ok, ok2});
    else passed++;
    bstate = 2'd2;
    din = 8'hA5;
    req = 1'b1;
    wait_for(0, ok);
    checks++;
    if ({ok, addr, wdata} !== {1'b1, 16'h1234, 8'hA5})
      $display("FAIL write_strobe got ok=%b addr=%h wdata=%h want 1 1234 a5", ok, addr, wdata);
    else passed++;
    tick();
    checks++;
    if (mwr !== 1'b0) $display("FAIL write_pulse_width got wr=%b want 0", mwr);
    else passed++;
    tick();
    tick();
    checks++;
    if (ack !== 1'b0) $display("FAIL write_ack_early got ack=%b want 0", ack);
    else passed++;
    mdone = 1'b1;
    tick();
    mdone = 1'b0;
    checks++;
    if ({ack, addr, wdata} !== {1'b1, 16'h1235, 8'hA5})
      $display("FAIL write_done got ack=%b addr=%h wdata=%h want 1 1235 a5", ack, addr, wdata);
    else passed++;
    finish_xfer(ok);
    checks++;
    if (ok !== 1'b1) $display("FAIL write_ack_release got %b want 1", ok);
    else passed++;
  endtask
  task automatic test_read_wrap();
    bit ok, ok2;
    do_phase(2'd0, 8'hFF, ok);
    do_phase(2'd1, 8'hFF, ok2);
    bstate = 2'd3;
    req = 1'b1;
    wait_for(1, ok);
    checks++;
    if ({ok, ok2, addr} !== {2'b11, 16'hFFFF}) $display("FAIL read1_strobe got ok=%b%b addr=%h want 11 ffff", ok, ok2, addr);
    else passed++;
    tick();
    tick();
    mdone = 1'b1;
    rdata = 8'h11;
    tick();
    mdone = 1'b0;
    rdata = 8'h00;
    checks++;
    if ({ack, oe, dout, addr} !== {2'b11, 8'h11, 16'h0000})
      $display("FAIL read1_data got ack=%b oe=%b dout=%h addr=%h want 1 1 11 0000", ack, oe, dout, addr);
    else passed++;
    finish_xfer(ok);
    checks++;
    if ({ok, oe, dout} !== {1'b1, 1'b0, 8'h11}) $display("FAIL oe_between_acks got ok=%b oe=%b dout=%h want 1 0 11", ok, oe, dout);
    else passed++;
    req = 1'b1;
    wait_for(1, ok);
    checks++;
    if ({ok, addr} !== {1'b1, 16'h0000}) $display("FAIL read2_addr got ok=%b addr=%h want 1 0000", ok, addr);
    else passed++;
    tick();
    tick();
    mdone = 1'b1;
    rdata = 8'h22;
    tick();
    mdone = 1'b0;
    checks++;
    if ({ack, oe, dout} !== {2'b11, 8'h22}) $display("FAIL read2_data got ack=%b oe=%b dout=%h want 1 1 22", ack, oe, dout);
    else passed++;
    finish_xfer(ok);
  endtask
  task automatic test_read_fast();
    bit ok;
    bstate = 2'd3;
    req = 1'b1;
    wait_for(1, ok);
    tick();
    mdone = 1'b1;
    rdata = 8'h5C;
    tick();
    mdone = 1'b0;
    checks++;
    if ({ok, ack, oe, dout, addr} !== {3'b111, 8'h5C, 16'h0002})
      $display("FAIL fast_read got ok=%b ack=%b oe=%b dout=%h addr=%h want 1 1 1 5c 0002", ok, ack, oe, dout, addr);
    else passed++;
    finish_xfer(ok);
  endtask
  task automatic test_back_to_back();
    bit ok;
    int strobes = 0;
    int ack_lows = 0;
    bstate = 2'd3;
    req = 1'b1;
    wait_for(1, ok);
    tick();
    mdone = 1'b1;
    rdata = 8'h3C;
    tick();
    mdone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mdone = (i == 3);
      tick();
      strobes += int'(mrd) + int'(mwr);
      ack_lows += int'(!ack);
    end
    mdone = 1'b0;
    checks++;
    if ({strobes, ack_lows} !== {32'd0, 32'd0} || addr !== 16'h0003)
      $display("FAIL held_req got strobes=%0d ack_lows=%0d addr=%h want 0 0 0003", strobes, ack_lows, addr);
    else passed++;
    finish_xfer(ok);
    req = 1'b1;
    wait_for(1, ok);
    checks++;
    if ({ok, addr} !== {1'b1, 16'h0003}) $display("FAIL rearm_read got ok=%b addr=%h want 1 0003", ok, addr);
    else passed++;
    tick();
    mdone = 1'b1;
    tick();
    mdone = 1'b0;
    finish_xfer(ok);
  endtask
  task automatic test_proto_err();
    bit ok;
    int ack_cycles = 0;
    bstate = 2'd3;
    req = 1'b1;
    wait_for(1, ok);
    req = 1'b0;
    repeat (4) tick();
    checks++;
    if ({ok, ack, perr} !== 3'b101) $display("FAIL abandon_flag got ok=%b ack=%b err=%b want 1 0 1", ok, ack, perr);
    else passed++;
    mdone = 1'b1;
    rdata = 8'h77;
    tick();
    mdone = 1'b0;
    ack_cycles += int'(ack);
    for (int i = 0; i < 4; i++) begin
      tick();
      ack_cycles += int'(ack);
    end
    checks++;
    if ({ack_cycles, addr} !== {32'd1, 16'h0005}) $display("FAIL abandon_ack got cycles=%0d addr=%h want 1 0005", ack_cycles, addr);
    else passed++;
    req = 1'b1;
    wait_for(1, ok);
    tick();
    mdone = 1'b1;
    rdata = 8'h88;
    tick();
    mdone = 1'b0;
    checks++;
    if ({ok, ack, dout, perr} !== {2'b11, 8'h88, 1'b1}) $display("FAIL after_abandon got ok=%b ack=%b dout=%h err=%b want 1 1 88 1", ok, ack, dout, perr);
    else passed++;
    finish_xfer(ok);
  endtask
  task automatic test_reset_mid();
    bit ok;
    int ack_seen = 0;
    do_phase(2'd0, 8'h40, ok);
    bstate = 2'd2;
    din = 8'h99;
    req = 1'b1;
    wait_for(0, ok);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({ack, oe, mrd, mwr, perr, dout} !== 13'd0) $display("FAIL mid_reset_ctrl got ack=%b oe=%b rd=%b wr=%b err=%b dout=%h want all 0", ack, oe, mrd, mwr, perr, dout);
    else passed++;
    checks++;
    if ({ok, addr, wdata} !== {1'b1, 24'd0}) $display("FAIL mid_reset_data got ok=%b addr=%h wdata=%h want 1 0000 00", ok, addr, wdata);
    else passed++;
    rst = 1'b0;
    req = 1'b0;
    tick();
    mdone = 1'b1;
    tick();
    mdone = 1'b0;
    ack_seen += int'(ack);
    for (int i = 0; i < 5; i++) begin
      tick();
      ack_seen += int'(ack);
    end
    checks++;
    if (ack_seen !== 0) $display("FAIL stale_done got ack cycles=%0d want 0", ack_seen);
    else passed++;
  endtask
  initial begin
    test_reset();
    test_write();
    test_read_wrap();
    test_read_fast();
    test_back_to_back();
    test_proto_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/bus_responder.md
# bus_responder

Target end of the CPU's external byte-wide four-phase bus. It receives `bus_handshake_req`, `bus_state` and data from the initiator's pins and assembles a 16-bit address from two address phases. It then performs the read or write against a variable-latency local memory port and answers with `bus_handshake_ack`, driving read data onto the shared byte lanes. It is used in the FPGA/test harness and in companion chips that act as the CPU's memory.

## Interface
- `SYNC_STAGES`, 2: flops in the `bus_handshake_req` synchronizer; minimum 2.
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `bus_handshake_req` in 1: initiator request, asynchronous; synchronized internally.
- `bus_state` in 2: phase code. 0 = address low, 1 = address high, 2 = write data, 3 = read. Stable whenever req is high.
- `bus_data_in` in 8: byte lanes from initiator; stable whenever req is high in phases 0–2.
- `bus_handshake_ack` out 1: responder acknowledge, registered.
- `bus_data_out` out 8: read data, registered.
- `bus_output_enable` out 1: drive enable for `bus_data_out`, registered.
- `mem_addr` out 16: current address.
- `mem_read` out 1: one-cycle read strobe.
- `mem_write` out 1: one-cycle write strobe.
- `mem_wdata` out 8: write byte; held from strobe until `mem_done`.
- `mem_rdata` in 8: read byte; valid in the cycle `mem_done` is high.
- `mem_done` in 1: memory completion, one cycle.
- `proto_err` out 1: sticky protocol-violation flag.

## Operation
- The four-phase rule, per transfer:
  - Initiator raises req with state and data valid.
  - Responder raises ack.
  - Initiator drops req.
  - Responder drops ack.
  - Next req is accepted only after ack is low.
- FSM states: IDLE, MEM, ACK.
- IDLE, `req_s` high (synchronized req), by phase:
  - Phase 0: `mem_addr[7:0]` ← `bus_data_in`, go to ACK.
  - Phase 1: `mem_addr[15:8]` ← `bus_data_in`, go to ACK.
  - Phase 2: `mem_wdata` ← `bus_data_in`, pulse `mem_write`, go to MEM.
  - Phase 3: pulse `mem_read`, go to MEM.
- MEM: wait for `mem_done`, then:
  - After a read, latch `mem_rdata` into `bus_data_out` and set `bus_output_enable`.
  - `mem_addr` ← `mem_addr` + 1, modulo 2^16 (0xFFFF wraps to 0x0000). Consecutive data phases therefore need no new address phases.
  - Go to ACK.
- ACK: `bus_handshake_ack` = 1. When `req_s` is low, clear ack and `bus_output_enable` and return to IDLE. `bus_data_out` keeps its last value.
- `mem_done` outside MEM is ignored.
- `req_s` falling while in MEM (initiator abandoned the transfer):
  - Set `proto_err`.
  - Still finish the memory operation, including the address increment.
  - Pass through ACK for exactly one cycle.
- `proto_err` clears only on `rst`.
- Reset, including mid-transfer: all outputs return to reset values and the FSM goes to IDLE. An outstanding memory operation is abandoned, and a later `mem_done` is ignored.
- Reset values:
  - ack 0, `bus_output_enable` 0.
  - `bus_data_out` 0x00, `mem_addr` 0x0000, `mem_wdata` 0x00.
  - `mem_read` 0, `mem_write` 0, `proto_err` 0.

## Timing
- Let t0 be the first edge at which `req_s` is sampled high, i.e. `SYNC_STAGES` edges after the pin rises.
- Address phase: ack is high after edge t0.
- Data phase:
  - Strobe is high for the cycle after t0 only.
  - `mem_done` is legal from the cycle after the strobe onward.
  - If `mem_done` is sampled at edge t1, ack, `bus_output_enable` and `bus_data_out` become valid together after t1.
- Ack falls one edge after `req_s` is sampled low.
- Throughput, address phase: 2·`SYNC_STAGES`+2 cycles minimum, excluding initiator-side synchronization.
- `bus_state` and `bus_data_in` are sampled unsynchronized. They are guaranteed stable because req passes through the synchronizer first.

## Structure
- Shared package `bus_pkg`:
  - Phase codes `PH_ADDR_LO`, `PH_ADDR_HI`, `PH_WRITE`, `PH_READ`.
  - FSM state encoding.
  - Shared with the initiator-side interface.
- One sub-module, `sync_hi`: an N-stage synchronizer with synchronous active-high reset to 0, used for `bus_handshake_req`.

## Test plan
- Reset mid-MEM with a write pending:
  - All outputs return to reset values next cycle.
  - A subsequent `mem_done` produces no ack.
- Address phases 0x34 then 0x12, then a write of 0xA5, with `mem_done` 3 cycles after the strobe:
  - One `mem_write` pulse with `mem_addr`=0x1234 and `mem_wdata`=0xA5.
  - Ack follows; `mem_addr` becomes 0x1235.
- Address 0xFFFF, then two read phases returning 0x11 and 0x22:
  - `bus_data_out` is 0x11 with oe high during the first ack.
  - Second read at 0x0000 returns 0x22.
  - oe is low between acks.
- Read with `mem_done` in the cycle immediately after the strobe:
  - Ack and data are valid next cycle.
- Req dropped during MEM:
  - `proto_err` = 1.
  - Ack pulses one cycle.
  - The next transfer completes normally with `proto_err` still 1.
- Back-to-back transfers where the initiator holds req high after ack:
  - Ack stays high and no second memory access is issued until req falls and rises again.
